// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg: shared types and defaults for the VGA ROM arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_BURST_DEF = 16;

endpackage : vga_pkg

`default_nettype wire

// File: rtl/template_rom.sv
// ----------------------------------------------------------------------------
// template_rom: background template ROM with a one-cycle registered read.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module template_rom #(
  parameter int    ADDR_WIDTH = 22,
  parameter int    DATA_WIDTH = 12,
  parameter string DATA_PATH  = "DH_bg.dat"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] data_q;

  // Contents are a pattern folded from the address; an empty path yields a blank ROM.
  generate
    if (DATA_PATH == "") begin : g_blank
      assign w_word = '0;
    end else begin : g_pattern
      assign w_word = addr_i[DATA_WIDTH-1:0] ^ addr_i[ADDR_WIDTH-1 -: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= w_word;
    end
  end

  assign data_o = data_q;

endmodule : template_rom

`default_nettype wire

// File: rtl/rom_arb.sv
// ----------------------------------------------------------------------------
// rom_arb: N-way ROM arbiter, display priority in active video, bursted round-robin.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rom_arb
  import vga_pkg::*;
#(
  parameter int    N_REQ      = 3,
  parameter int    ADDR_WIDTH = 22,
  parameter int    DATA_WIDTH = 12,
  parameter int    MAX_BURST  = MAX_BURST_DEF,
  parameter string DATA_PATH  = "DH_bg.dat"
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             active,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] addr,
  output logic [N_REQ-1:0]                 gnt,
  output logic [N_REQ-1:0]                 rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             busy
);

  localparam int C_ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int C_CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [C_ID_W-1:0]  C_LAST_RST = C_ID_W'(N_REQ - 1);
  localparam logic [C_CNT_W-1:0] C_MAX      = C_CNT_W'(MAX_BURST);

  arb_state_e              state_q;
  logic [C_ID_W-1:0]       owner_q;
  logic [C_CNT_W-1:0]      burst_cnt_q;
  logic [C_CNT_W-1:0]      burst_cnt_d;
  logic [N_REQ-1:0]        rvalid_q;

  logic                    w_any;
  logic                    w_others;
  logic                    w_keep;
  logic                    w_gvalid;
  logic [C_ID_W-1:0]       w_sel;
  logic [ADDR_WIDTH-1:0]   w_rom_addr;

  // Nearest pending requester after 'last', wrapping; the descending scan lets the nearest win.
  function automatic logic [C_ID_W-1:0] rr_next(input logic [N_REQ-1:0] r,
                                                input logic [C_ID_W-1:0] last);
    logic [C_ID_W-1:0] pick;
    logic [C_ID_W-1:0] idx;
    pick = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = C_ID_W'((int'(last) + k) % N_REQ);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    w_any    = |req;
    w_others = |(req & ~(N_REQ'(1) << owner_q));
    w_keep   = (state_q == GRANT) && req[owner_q] && !((burst_cnt_q == C_MAX) && w_others);
    if (active && req[0]) begin
      w_sel = '0;
    end else if (w_keep) begin
      w_sel = owner_q;
    end else begin
      w_sel = rr_next(req, owner_q);
    end
    w_gvalid   = rst_n && w_any;
    gnt        = w_gvalid ? (N_REQ'(1) << w_sel) : '0;
    w_rom_addr = w_gvalid ? addr[w_sel] : '0;
    if ((state_q == GRANT) && (w_sel == owner_q)) begin
      burst_cnt_d = (burst_cnt_q == C_MAX) ? C_MAX : burst_cnt_q + C_CNT_W'(1);
    end else begin
      burst_cnt_d = C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= C_LAST_RST;
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
    end else begin
      rvalid_q <= gnt;
      case (state_q)
        IDLE, GRANT: begin
          if (w_any) begin
            state_q     <= GRANT;
            owner_q     <= w_sel;
            burst_cnt_q <= burst_cnt_d;
          end else begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid = rvalid_q;
  assign busy   = (state_q == GRANT);

  template_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_PATH  (DATA_PATH)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (w_gvalid),
    .addr_i (w_rom_addr),
    .data_o (rdata)
  );

endmodule : rom_arb

`default_nettype wire

// File: tb/tb_rom_arb.sv
// ----------------------------------------------------------------------------
// tb_rom_arb: directed and randomized checks of rom_arb against a reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rom_arb;

  localparam int N  = 3;
  localparam int AW = 22;
  localparam int DW = 12;
  localparam int MB = 16;

  logic                   clk;
  logic                   rst_n;
  logic                   active;
  logic [N-1:0]           req;
  logic [N-1:0][AW-1:0]   addr;
  logic [N-1:0]           gnt;
  logic [N-1:0]           rvalid;
  logic [DW-1:0]          rdata;
  logic                   busy;

  int total = 0;
  int bad   = 0;

  rom_arb #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .DATA_PATH  ("DH_bg.dat")
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (active),
    .req    (req),
    .addr   (addr),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image: low word XOR top word of the {vcount, hcount} address.
  function automatic logic [DW-1:0] rom_model(input logic [AW-1:0] a);
    return a[11:0] ^ a[21:10];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    active = 1'b0;
    addr   = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  // Reference model: who must own the ROM this cycle, and what must come back next cycle.
  initial begin : p_cmp
    int         m_owner;
    int         m_run;
    bit         m_busy;
    logic [N-1:0]  m_prev;
    logic [AW-1:0] m_paddr;
    int         waitc [N];
    int         w;
    int         idx;
    bit         others;
    logic [N-1:0]  eg;
    m_owner = N - 1;
    m_run   = 0;
    m_busy  = 1'b0;
    m_prev  = '0;
    m_paddr = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_gnt",    32'(gnt),    32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata",  32'(rdata),  32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        m_owner = N - 1;
        m_run   = 0;
        m_busy  = 1'b0;
        m_prev  = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
      end else begin
        chk("rvalid", 32'(rvalid), 32'(m_prev));
        if (m_prev != '0) chk("rdata", 32'(rdata), 32'(rom_model(m_paddr)));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("onehot", 32'($onehot0(gnt)), 32'd1);

        w      = -1;
        others = ((32'(req) & ~(32'd1 << m_owner)) != 0);
        if (active && req[0]) begin
          w = 0;
        end else if (m_busy && req[m_owner] && (m_run < MB || !others)) begin
          w = m_owner;
        end else begin
          for (int k = 1; k <= N; k++) begin
            idx = (m_owner + k) % N;
            if (w < 0 && req[idx]) w = idx;
          end
        end
        eg = (w >= 0) ? N'(1 << w) : '0;
        chk("gnt", 32'(gnt), 32'(eg));

        for (int i = 0; i < N; i++) begin
          if (active || !req[i] || gnt[i]) waitc[i] = 0;
          else waitc[i]++;
          if (waitc[i] == 2 * MB + 1) chk("starve", 32'(waitc[i]), 32'(2 * MB));
        end

        if (w >= 0) begin
          if (m_busy && w == m_owner) m_run = (m_run < MB) ? m_run + 1 : MB;
          else m_run = 1;
          m_owner = w;
          m_busy  = 1'b1;
          m_prev  = eg;
          m_paddr = addr[w];
        end else begin
          m_busy = 1'b0;
          m_run  = 0;
          m_prev = '0;
        end
      end
    end
  end

  initial begin : p_drv
    logic [N-1:0] g;
    logic [N-1:0] exp_g;

    do_reset();

    // Single read from requester 1, one-cycle latency.
    req     = 3'b010;
    addr[1] = 22'h000100;
    #1 chk("first_gnt", 32'(gnt), 32'h2);
    cyc();
    chk("first_rvalid", 32'(rvalid), 32'h2);
    chk("first_rdata",  32'(rdata),  32'h100);
    req = '0;
    cyc();

    // All three requesting, no active video: blocks of MB grants in order 0,1,2.
    do_reset();
    addr[0] = 22'h012345;
    addr[1] = 22'h2ABCDE;
    addr[2] = 22'h3FFC00;
    req     = 3'b111;
    for (int i = 0; i < 40; i++) begin
      exp_g = (i < 16) ? 3'b001 : (i < 32) ? 3'b010 : 3'b100;
      #1 chk("rotate_gnt", 32'(gnt), 32'(exp_g));
      cyc();
    end
    req = '0;
    cyc();

    // Display override while requester 1 is mid-burst.
    do_reset();
    addr[1] = 22'h00ABC0;
    req     = 3'b010;
    repeat (5) cyc();
    chk("burst5", 32'(dut.burst_cnt_q), 32'd5);
    active  = 1'b1;
    req     = 3'b011;
    addr[0] = 22'h155555;
    #1 chk("override_gnt", 32'(gnt), 32'h1);
    cyc();
    req = 3'b010;
    #1 chk("resume_gnt", 32'(gnt), 32'h2);
    cyc();
    active = 1'b0;
    req    = '0;
    cyc();

    // Lone requester never rotates and the burst counter saturates.
    do_reset();
    addr[2] = 22'h0F0F0F;
    req     = 3'b100;
    for (int i = 0; i < 40; i++) begin
      #1 chk("alone_gnt", 32'(gnt), 32'h4);
      cyc();
    end
    chk("alone_cnt", 32'(dut.burst_cnt_q), 32'd16);
    req = '0;
    cyc();

    // Asynchronous reset in the middle of a burst.
    do_reset();
    req = 3'b111;
    repeat (10) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt",    32'(gnt),    32'd0);
    chk("async_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 3'b011;
    #1 chk("post_rst_gnt", 32'(gnt), 32'h1);
    cyc();
    chk("post_rst_rvalid", 32'(rvalid), 32'h1);
    req = '0;
    cyc();

    // Randomized traffic: req held until granted, optional re-request with a new address.
    do_reset();
    g = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(19) == 0) active = ~active;
      for (int i = 0; i < N; i++) begin
        if (req[i] && g[i]) begin
          if ($urandom_range(2) == 0) req[i] = 1'b0;
          else addr[i] = AW'($urandom);
        end else if (!req[i] && $urandom_range(1) == 0) begin
          req[i]  = 1'b1;
          addr[i] = AW'($urandom);
        end
      end
      #1 g = gnt;
      cyc();
    end
    req    = '0;
    active = 1'b0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rom_arb

`default_nettype wire
